// File: rtl/fifo_rd_arb_pkg.sv
// Shared types for the FIFO read-side arbiter: FSM state encoding and
// the per-consumer statistics counter width.
package fifo_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr,
// searching cyclically, returned as one-hot and as an index.
module fifo_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh[pick_idx] = pick_valid;
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side round-robin, bounded-burst scheduler for the async FIFO read port.
// Optional per-consumer word counters are built when FIFO_RD_ARB_STATS_EN is defined.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    ready,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
`ifdef FIFO_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] burst_cnt;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // A dropped request releases the grant without reading; a read on the
  // last burst slot completes and then releases.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = BURST;
      end
      BURST: begin
        fifo_rd_en = req[gnt_idx] & ready[gnt_idx] & ~fifo_empty;
        if (!req[gnt_idx] || (fifo_rd_en && burst_cnt == CNT_W'(MAX_BURST - 1)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= '0;
      if (fifo_rd_en) begin
        out_valid <= gnt;
        out_data  <= fifo_rd_data;
      end
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt       <= pick_oh;
            gnt_idx   <= pick_idx;
            burst_cnt <= '0;
          end
        end
        BURST: begin
          if (state_nxt == IDLE) begin
            gnt       <= '0;
            burst_cnt <= '0;
            rr_ptr    <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          end else if (fifo_rd_en) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == BURST);

`ifdef FIFO_RD_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (out_valid[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + STAT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_cnt[g*STAT_WIDTH +: STAT_WIDTH] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: cycle table for the single-requester case, then
// scoreboarded sequences; the counter test runs when FIFO_RD_ARB_STATS_EN is defined.
module tb_fifo_rd_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int EW = DW + 3;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic [NR-1:0] req    = '0;
  logic [NR-1:0] ready  = '0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [NR-1:0] gnt;
  logic [NR-1:0] out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
`ifdef FIFO_RD_ARB_STATS_EN
  logic [NR*16-1:0] stat_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic sb_on = 1'b0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 rd_clk = ~rd_clk;

  fifo_rd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .req          (req),
    .ready        (ready),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .gnt          (gnt),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy)
`ifdef FIFO_RD_ARB_STATS_EN
    ,
    .stat_cnt     (stat_cnt)
`endif
  );

  // ---------------- FIFO model: show-ahead data, pop on rd_en ----------------
  logic [DW-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = mem[rd_ptr[7:0]];
  always @(posedge rd_clk) if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge rd_clk); #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr++;
  endtask

  task automatic expect_word(input int idx, input logic [DW-1:0] d);
    exp_q.push_back({3'(idx), d});
  endtask

  task automatic reset_dut();
    sb_on  = 1'b0;
    req    = '0;
    ready  = '0;
    rd_rst = 1'b1;
    step();
    wr_ptr = rd_ptr;
    exp_q.delete();
    rd_rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      step();
      cyc++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge rd_clk) begin
    if (sb_on) begin
      chk("rd_en_legal", fifo_rd_en, busy && ((gnt & req & ready) != 0) && !fifo_empty);
      if (out_valid != 0) begin
        int idx;
        logic [EW-1:0] exp_e;
        idx = 0;
        for (int k = 0; k < NR; k++) if (out_valid[k]) idx = k;
        chk("ov_onehot", $countones(out_valid), 1);
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", {3'(idx), out_data}, '1);
        end else begin
          exp_e = exp_q.pop_front();
          chk("sb_word", {3'(idx), out_data}, exp_e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [NR-1:0] req;
    logic          push;
    logic [DW-1:0] push_data;
    logic [NR-1:0] gnt;
    logic          busy;
    logic          rd_en;
    logic [NR-1:0] ov;
    logic [DW-1:0] od;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cyc;
    vecs[0]  = '{4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00};
    vecs[1]  = '{4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b1, 4'b0000, 8'h00};
    vecs[2]  = '{4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b1, 4'b0010, 8'hA1};
    vecs[3]  = '{4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b1, 4'b0010, 8'hA2};
    vecs[4]  = '{4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 4'b0010, 8'hA3};
    vecs[5]  = '{4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 4'b0000, 8'hA3};
    vecs[6]  = '{4'b0010, 1'b1, 8'hA4, 4'b0010, 1'b1, 1'b1, 4'b0000, 8'hA3};
    vecs[7]  = '{4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 4'b0010, 8'hA4};
    vecs[8]  = '{4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 4'b0000, 8'hA4};
    vecs[9]  = '{4'b0000, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0, 4'b0000, 8'hA4};
    vecs[10] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'hA4};

    // Single requester: short FIFO, empty stall, max-burst exit, re-grant, release.
    reset_dut();
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    ready = '1;
    for (int i = 0; i < 11; i++) begin
      req = vecs[i].req;
      if (vecs[i].push) push_word(vecs[i].push_data);
      @(negedge rd_clk);
      chk($sformatf("v%0d_gnt", i),   gnt,        vecs[i].gnt);
      chk($sformatf("v%0d_busy", i),  busy,       vecs[i].busy);
      chk($sformatf("v%0d_rd_en", i), fifo_rd_en, vecs[i].rd_en);
      chk($sformatf("v%0d_ov", i),    out_valid,  vecs[i].ov);
      chk($sformatf("v%0d_od", i),    out_data,   vecs[i].od);
      step();
    end

    // Round robin over all four consumers, one idle cycle between bursts.
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      push_word(8'(8'h10 + i));
      expect_word((i / MB) % NR, 8'(8'h10 + i));
    end
    sb_on = 1'b1;
    req   = 4'b1111;
    ready = 4'b1111;
    wait_drain(60, cyc);
    chk("rr_cycles", cyc, 26);
    req = '0;
    repeat (3) step();

    // Backpressure: ready low for three cycles mid-burst.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      push_word(8'(8'h30 + i));
      expect_word(2, 8'(8'h30 + i));
    end
    sb_on = 1'b1;
    req   = 4'b0100;
    ready = 4'b1111;
    repeat (3) step();
    ready = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge rd_clk);
      chk("bp_rd_en", fifo_rd_en, 1'b0);
      chk("bp_gnt", gnt, 4'b0100);
      step();
    end
    ready = 4'b1111;
    wait_drain(20, cyc);
    repeat (3) step();
    req = '0;
    repeat (2) step();

    // FIFO drains mid-burst, refilled five cycles later.
    reset_dut();
    push_word(8'h40); push_word(8'h41);
    for (int i = 0; i < 4; i++) expect_word(3, 8'(8'h40 + i));
    sb_on = 1'b1;
    req   = 4'b1000;
    ready = 4'b1111;
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      @(negedge rd_clk);
      chk("emp_rd_en", fifo_rd_en, 1'b0);
      chk("emp_gnt", gnt, 4'b1000);
      chk("emp_busy", busy, 1'b1);
      step();
    end
    push_word(8'h42); push_word(8'h43);
    repeat (2) step();
    @(negedge rd_clk);
    chk("emp_release", gnt, 4'b0000);
    wait_drain(20, cyc);
    req = '0;
    repeat (3) step();

    // Reset on the second read of consumer 2's burst.
    reset_dut();
    for (int i = 0; i < 8; i++) push_word(8'(8'h50 + i));
    for (int i = 0; i < 4; i++) expect_word(1, 8'(8'h50 + i));
    expect_word(2, 8'h54);
    expect_word(1, 8'h56);
    expect_word(1, 8'h57);
    sb_on = 1'b1;
    req   = 4'b0110;
    ready = 4'b1111;
    repeat (7) step();
    rd_rst = 1'b1;
    @(negedge rd_clk);
    chk("rst_pre_gnt", gnt, 4'b0100);
    chk("rst_pre_rd_en", fifo_rd_en, 1'b1);
    step();
    rd_rst = 1'b0;
    @(negedge rd_clk);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_ov", out_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_od", out_data, 8'h00);
    step();
    @(negedge rd_clk);
    chk("rst_regrant", gnt, 4'b0010);
    wait_drain(20, cyc);
    req = '0;
    repeat (3) step();

`ifdef FIFO_RD_ARB_STATS_EN
    // Counter saturation on consumer 0.
    begin
      int delivered;
      int n;
      reset_dut();
      chk("stat_reset0", stat_cnt[31:0], 32'h0);
      req       = 4'b0001;
      ready     = 4'b1111;
      delivered = 0;
      n         = 0;
      while (delivered < 65540 && n < 90000) begin
        if (wr_ptr - rd_ptr < 4) push_word(8'(n));
        @(negedge rd_clk);
        if (out_valid[0]) delivered++;
        step();
        n++;
      end
      chk("stat_delivered", delivered, 65540);
      chk("stat_sat0", stat_cnt[15:0], 16'hFFFF);
      chk("stat_c1", stat_cnt[31:16], 16'h0);
      chk("stat_c2", stat_cnt[47:32], 16'h0);
      chk("stat_c3", stat_cnt[63:48], 16'h0);
      reset_dut();
      chk("stat_clear", stat_cnt[15:0], 16'h0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
